// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM L/H slot receiver: schedule state encoding and default timing.
package tdm_pkg;

  localparam int unsigned DW_DEF        = 16;
  localparam int unsigned SLOT_LEN_DEF  = 10;
  localparam int unsigned GUARD_LEN_DEF = 2;
  localparam int unsigned DEPTH_DEF     = 4;

  // Par label map:  IDLE -> L   L_SLOT -> L   H_SLOT -> H   GUARD -> L
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    L_SLOT = 2'd1,
    H_SLOT = 2'd2,
    GUARD  = 2'd3
  } slot_state_e;

endpackage

// File: rtl/tdm_slot_receiver_if.sv
// Channel-side and per-domain consumer signals of the TDM slot receiver.
interface tdm_slot_receiver_if
  import tdm_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);

  logic          rx_sof;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic [DW-1:0] l_data;
  logic          l_valid;
  logic          l_ready;
  logic          l_ovf;
  logic [DW-1:0] h_data;
  logic          h_valid;
  logic          h_ready;
  logic          h_ovf;
  logic [1:0]    slot;

  modport master (
    output rx_sof, rx_valid, rx_data, l_ready, h_ready,
    input  l_data, l_valid, l_ovf, h_data, h_valid, h_ovf, slot
  );

  modport slave (
    input  rx_sof, rx_valid, rx_data, l_ready, h_ready,
    output l_data, l_valid, l_ovf, h_data, h_valid, h_ovf, slot
  );

endinterface

// File: rtl/slot_fifo.sv
// Single-domain synchronous FIFO with registered first-word-through head and sticky overflow flag.
module slot_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          valid,
  output logic          ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_n [DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_n, rd_n;
  logic          full, empty, pop_ok, push_ok;

  // Pop is resolved before push so a full FIFO can accept a word in the same cycle it drains one.
  always_comb begin
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    empty   = (wr_q == rd_q);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    mem_n   = mem_q;
    if (push_ok) mem_n[wr_q[AW-1:0]] = push_data;
    wr_n    = wr_q + PW'(push_ok);
    rd_n    = rd_q + PW'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      head  <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      mem_q <= mem_n;
      wr_q  <= wr_n;
      rd_q  <= rd_n;
      head  <= mem_n[rd_n[AW-1:0]];
      valid <= (wr_n != rd_n);
      if (push && !push_ok) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/tdm_slot_receiver.sv
// Receive side of the L/H time-multiplexed channel: tracks the slot schedule and steers words into per-domain FIFOs.
module tdm_slot_receiver
  import tdm_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned SLOT_LEN  = SLOT_LEN_DEF,
  parameter int unsigned GUARD_LEN = GUARD_LEN_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  tdm_slot_receiver_if.slave  bus
);

  localparam int unsigned TMAX = (SLOT_LEN > GUARD_LEN) ? SLOT_LEN : GUARD_LEN;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  slot_state_e   state_q, state_n;
  logic [TW-1:0] timer_q, timer_n;
  logic          last_h_q, last_h_n;
  logic          l_push, h_push;

  // Schedule driven only by rx_sof and the free-running timer; no H-side signal enters here.
  always_comb begin
    state_n  = state_q;
    timer_n  = timer_q;
    last_h_n = last_h_q;
    l_push   = bus.rx_valid && (state_q == L_SLOT);
    h_push   = bus.rx_valid && (state_q == H_SLOT);
    if (bus.rx_sof) begin
      state_n = L_SLOT;
      timer_n = TW'(SLOT_LEN - 1);
    end else begin
      unique case (state_q)
        IDLE: timer_n = '0;
        L_SLOT, H_SLOT: begin
          if (timer_q == '0) begin
            state_n  = GUARD;
            timer_n  = TW'(GUARD_LEN - 1);
            last_h_n = (state_q == H_SLOT);
          end else begin
            timer_n = timer_q - TW'(1);
          end
        end
        GUARD: begin
          if (timer_q == '0) begin
            state_n = last_h_q ? L_SLOT : H_SLOT;
            timer_n = TW'(SLOT_LEN - 1);
          end else begin
            timer_n = timer_q - TW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      last_h_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      timer_q  <= timer_n;
      last_h_q <= last_h_n;
    end
  end

  assign bus.slot = state_q;

  slot_fifo #(.DW(DW), .DEPTH(DEPTH)) u_l_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (l_push),
    .push_data (bus.rx_data),
    .pop       (bus.l_ready),
    .head      (bus.l_data),
    .valid     (bus.l_valid),
    .ovf       (bus.l_ovf)
  );

  slot_fifo #(.DW(DW), .DEPTH(DEPTH)) u_h_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (h_push),
    .push_data (bus.rx_data),
    .pop       (bus.h_ready),
    .head      (bus.h_data),
    .valid     (bus.h_valid),
    .ovf       (bus.h_ovf)
  );

endmodule

// File: tb/tb_tdm_slot_receiver.sv
// Scoreboard bench for tdm_slot_receiver: schedule model from cycle arithmetic, queue-based FIFO model.
module tb_tdm_slot_receiver;
  import tdm_pkg::*;

  localparam int unsigned DW      = 16;
  localparam int unsigned SLOT    = 10;
  localparam int unsigned GLEN    = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PERIOD  = 2 * (SLOT + GLEN);
  localparam int          TR_N    = 160;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_slot_receiver_if #(.DW(DW)) bus ();

  tdm_slot_receiver #(
    .DW(DW), .SLOT_LEN(SLOT), .GUARD_LEN(GLEN), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: schedule position is just cycles elapsed since the last rx_sof.
  logic [DW-1:0] exp_l[$];
  logic [DW-1:0] exp_h[$];
  bit            m_lovf, m_hovf, sof_seen;
  int            cyc_since;
  slot_state_e   m_st;

  function automatic slot_state_e model_state();
    int p;
    if (!sof_seen) return IDLE;
    p = cyc_since % PERIOD;
    if (p < SLOT)            return L_SLOT;
    if (p < SLOT + GLEN)     return GUARD;
    if (p < 2 * SLOT + GLEN) return H_SLOT;
    return GUARD;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_l.delete();
      exp_h.delete();
      m_lovf    = 1'b0;
      m_hovf    = 1'b0;
      sof_seen  = 1'b0;
      cyc_since = 0;
    end else begin
      m_st = model_state();
      if (bus.rx_valid && m_st == L_SLOT) begin
        if (exp_l.size() < DEPTH) exp_l.push_back(bus.rx_data);
        else m_lovf = 1'b1;
      end else if (bus.rx_valid && m_st == H_SLOT) begin
        if (exp_h.size() < DEPTH) exp_h.push_back(bus.rx_data);
        else m_hovf = 1'b1;
      end
      if (bus.rx_sof) begin
        sof_seen  = 1'b1;
        cyc_since = 0;
      end else if (sof_seen) begin
        cyc_since++;
      end
    end
  end

  // Monitor: compares every output each cycle, pops expected words as the consumers take them.
  int          cyc      = 0;
  int          rec_mode = 0;
  logic [19:0] trace [TR_N];

  always @(negedge clk) begin
    check("slot", 32'(bus.slot), 32'(model_state()));
    check("l_valid", 32'(bus.l_valid), 32'(exp_l.size() != 0));
    check("h_valid", 32'(bus.h_valid), 32'(exp_h.size() != 0));
    check("l_ovf", 32'(bus.l_ovf), 32'(m_lovf));
    check("h_ovf", 32'(bus.h_ovf), 32'(m_hovf));
    if (rst) begin
      check("l_data_rst", 32'(bus.l_data), 32'd0);
      check("h_data_rst", 32'(bus.h_data), 32'd0);
    end
    if (exp_l.size() != 0) begin
      check("l_data", 32'(bus.l_data), 32'(exp_l[0]));
      if (bus.l_ready) void'(exp_l.pop_front());
    end
    if (exp_h.size() != 0) begin
      check("h_data", 32'(bus.h_data), 32'(exp_h[0]));
      if (bus.h_ready) void'(exp_h.pop_front());
    end
    if (cyc >= 0 && cyc < TR_N) begin
      if (rec_mode == 1)
        trace[cyc] = {bus.slot, bus.l_valid, bus.l_ovf, bus.l_data};
      else if (rec_mode == 2)
        check("l_trace", 32'({bus.slot, bus.l_valid, bus.l_ovf, bus.l_data}), 32'(trace[cyc]));
    end
  end

  task automatic cycle(input bit sof, input bit v, input logic [DW-1:0] d,
                       input bit lr, input bit hr);
    bus.rx_sof   = sof;
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.l_ready  = lr;
    bus.h_ready  = hr;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  bit            sof_a  [TR_N];
  bit            lval_a [TR_N];
  logic [DW-1:0] ldat_a [TR_N];
  bit            lr_a   [TR_N];

  initial begin
    rst          = 1'b1;
    bus.rx_sof   = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.l_ready  = 1'b0;
    bus.h_ready  = 1'b0;
    @(posedge clk);
    #2;
    do_reset();

    // Schedule and steering: sof at cycle 3, a word every cycle carrying the cycle number.
    for (int c = 0; c < 80; c++)
      cycle(c == 3, 1'b1, DW'(c), 1'b1, 1'b1);

    // Overflow: five L-slot words into a four-deep FIFO with no consumer, then drain.
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      cycle(1'b0, 1'b1, DW'(16'hA000 + k), 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("l_ovf_after_5", 32'(bus.l_ovf), 32'd1);
    check("h_ovf_after_5", 32'(bus.h_ovf), 32'd0);
    repeat (6) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Non-interference: identical L stimulus, independently randomised H-side inputs.
    for (int i = 0; i < TR_N; i++) begin
      sof_a[i]  = (i == 2) || ($urandom_range(0, 79) == 0);
      lval_a[i] = 1'($urandom);
      ldat_a[i] = DW'($urandom);
      lr_a[i]   = 1'($urandom);
    end
    for (int r = 0; r < 2; r++) begin
      do_reset();
      rec_mode = r + 1;
      for (int i = 0; i < TR_N; i++) begin
        bit hs;
        cyc = i;
        hs  = (model_state() == H_SLOT);
        cycle(sof_a[i], hs ? 1'($urandom) : lval_a[i], hs ? DW'($urandom) : ldat_a[i],
              lr_a[i], 1'($urandom));
      end
      rec_mode = 0;
      cyc      = -1;
    end

    // Resync mid H slot: contents of both FIFOs survive, schedule restarts at L_SLOT.
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < SLOT + GLEN + 4; k++)
      cycle(1'b0, (k % 3) == 0, DW'(16'hB000 + k), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("slot_after_resync", 32'(bus.slot), 32'(L_SLOT));
    repeat (SLOT + GLEN + 2) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Asynchronous reset mid L slot with three words queued.
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 1'b1, DW'(16'hC000 + k), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("l_valid_before_rst", 32'(bus.l_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("l_valid_async_rst", 32'(bus.l_valid), 32'd0);
    check("slot_async_rst", 32'(bus.slot), 32'(IDLE));
    check("l_data_async_rst", 32'(bus.l_data), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (12) cycle(1'b0, 1'b1, 16'hD00D, 1'b1, 1'b1);
    check("slot_idle_no_sof", 32'(bus.slot), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
